// File: rtl/lfsr_seq_if.sv
// Bus between the LFSR test sequencer and its host/datapath neighbours.
// Signal names are written from the sequencer's side: i_* flow into the sequencer,
// o_* flow out of it.
//   slave  : the sequencer itself
//   master : host + LFSR datapath (drives start/abort/seed/lock, observes status)
// Optional macro LFSR_SEQ_INJECT_EN adds i_inj_at / i_inj_len.
interface lfsr_seq_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             i_start;
    logic             i_abort;
    logic [7:0]       i_seed;
    logic             i_lock;
`ifdef LFSR_SEQ_INJECT_EN
    logic [CNT_W-1:0] i_inj_at;
    logic [7:0]       i_inj_len;
`endif
    logic             o_soft_rst;
    logic [7:0]       o_seed;
    logic             o_valid;
    logic             o_corrupt;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic             o_timeout;
    logic [CNT_W-1:0] o_lock_time;
    logic [7:0]       o_loss_cnt;

    modport slave (
        input  i_start, i_abort, i_seed, i_lock,
`ifdef LFSR_SEQ_INJECT_EN
        input  i_inj_at, i_inj_len,
`endif
        output o_soft_rst, o_seed, o_valid, o_corrupt, o_busy, o_done, o_pass,
               o_timeout, o_lock_time, o_loss_cnt
    );

    modport master (
        output i_start, i_abort, i_seed, i_lock,
`ifdef LFSR_SEQ_INJECT_EN
        output i_inj_at, i_inj_len,
`endif
        input  o_soft_rst, o_seed, o_valid, o_corrupt, o_busy, o_done, o_pass,
               o_timeout, o_lock_time, o_loss_cnt
    );
endinterface

// File: rtl/lfsr_test_sequencer.sv
// Test controller for the 8-bit LFSR generator/checker pair.
// Sequence: IDLE -> SEED (1-cycle soft reset, seed applied) -> ACQUIRE (paced valid
// strobes until the checker locks or the timeout expires) -> RUN (fixed-length soak,
// counting lock losses) -> DONE (1-cycle o_done with pass/fail) -> IDLE.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : lfsr_seq_if.slave -- start/abort/seed/lock in; soft_rst/seed/valid/corrupt to
//          the datapath; busy/done/pass/timeout/lock_time/loss_cnt status out
// Optional macro LFSR_SEQ_INJECT_EN: enables error injection over a window of RUN strobes
// (i_inj_at/i_inj_len latched at start) and changes the pass rule to require detection.
module lfsr_test_sequencer #(
    parameter int unsigned VALID_DIV    = 2,
    parameter int unsigned LOCK_TIMEOUT = 255,
    parameter int unsigned RUN_LEN      = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input logic       clk,
    input logic       rst,
    lfsr_seq_if.slave bus
);
    localparam int unsigned      PaceW   = $clog2(VALID_DIV);
    localparam logic [PaceW-1:0] PaceMax = PaceW'(VALID_DIV - 1);
    localparam logic [CNT_W-1:0] LockTo  = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] RunLen  = CNT_W'(RUN_LEN);

    typedef enum logic [2:0] {StIdle, StSeed, StAcq, StRun, StDone} state_e;

    state_e           state_q;
    logic [PaceW-1:0] pace_q, pace_d;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [7:0]       seed_q;
    logic [CNT_W-1:0] lock_time_q;
    logic [7:0]       loss_q, loss_d;
    logic             lock_d_q;
    logic             soft_rst_q, valid_q, busy_q, done_q, pass_q, timeout_q;
    logic             run_pass;
    logic             corrupt;

`ifdef LFSR_SEQ_INJECT_EN
    localparam int unsigned InjW = CNT_W + 1;
    logic [CNT_W-1:0] inj_at_q;
    logic [7:0]       inj_len_q;
    logic [InjW-1:0]  inj_end;

    // Window is [at, at+len-1] in RUN strobe indices; cnt_q is the index of the next strobe.
    assign inj_end = {1'b0, inj_at_q} + InjW'(inj_len_q);
    assign corrupt = (state_q == StRun) && (inj_len_q != 8'd0) && (cnt_q >= inj_at_q) &&
                     ({1'b0, cnt_q} < inj_end);
`else
    assign corrupt = 1'b0;
`endif

    always_comb begin
        pace_d  = (pace_q == PaceMax) ? '0 : pace_q + PaceW'(1);
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        loss_d  = loss_q;
        if (lock_d_q && !bus.i_lock && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
        run_pass = (loss_d == 8'd0) && bus.i_lock;
`ifdef LFSR_SEQ_INJECT_EN
        // With injection the checker must have noticed at least once and relocked.
        if (inj_len_q != 8'd0) begin
            run_pass = (loss_d != 8'd0) && bus.i_lock;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pace_q      <= '0;
            cnt_q       <= '0;
            seed_q      <= 8'h00;
            lock_time_q <= '0;
            loss_q      <= 8'h00;
            lock_d_q    <= 1'b0;
            soft_rst_q  <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef LFSR_SEQ_INJECT_EN
            inj_at_q    <= '0;
            inj_len_q   <= 8'h00;
`endif
        end else begin
            soft_rst_q <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            lock_d_q   <= bus.i_lock;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        seed_q      <= bus.i_seed;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        lock_time_q <= '0;
                        loss_q      <= 8'h00;
                        busy_q      <= 1'b1;
                        soft_rst_q  <= 1'b1;
                        state_q     <= StSeed;
`ifdef LFSR_SEQ_INJECT_EN
                        inj_at_q    <= bus.i_inj_at;
                        inj_len_q   <= bus.i_inj_len;
`endif
                    end
                end
                StSeed: begin
                    if (bus.i_abort) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else begin
                        pace_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= StAcq;
                    end
                end
                StAcq: begin
                    if (bus.i_abort) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else if (bus.i_lock) begin
                        // Strobes completed before the lock cycle; pacer keeps its phase.
                        lock_time_q <= cnt_q;
                        cnt_q       <= '0;
                        pace_q      <= pace_d;
                        valid_q     <= (pace_d == PaceMax);
                        state_q     <= StRun;
                    end else if (valid_q && (cnt_inc >= LockTo)) begin
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        if (valid_q) begin
                            cnt_q <= cnt_inc;
                        end
                        pace_q  <= pace_d;
                        valid_q <= (pace_d == PaceMax);
                    end
                end
                StRun: begin
                    if (bus.i_abort) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else begin
                        loss_q <= loss_d;
                        if (valid_q && (cnt_inc >= RunLen)) begin
                            pass_q  <= run_pass;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            if (valid_q) begin
                                cnt_q <= cnt_inc;
                            end
                            pace_q  <= pace_d;
                            valid_q <= (pace_d == PaceMax);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_soft_rst  = soft_rst_q;
    assign bus.o_seed      = seed_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_corrupt   = corrupt;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_pass      = pass_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_lock_time = lock_time_q;
    assign bus.o_loss_cnt  = loss_q;
endmodule
